spi_ctrl_tx: RTL and testbench
==============================

SPI_CTRL_TX -- requirements
Module: spi_ctrl_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal values are 2..255.
REQ-002 SHALL have port clk  in  1: system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-004 SHALL have port tx_data  in  8: byte to send, MSB first.
REQ-005 SHALL have port tx_valid  in  1: a byte is offered.
REQ-006 SHALL have port tx_ready  out  1: the block can accept a byte.
REQ-007 SHALL have port mode  in  2: SPI mode; mode[1]=CPOL, mode[0]=CPHA.
REQ-008 SHALL have port miso  in  1: serial data from the peripheral.
REQ-009 SHALL have ports sclk, mosi, cs  out  1 each: SPI bus; cs is active-low.
REQ-010 SHALL have port rx_data  out  8: byte captured from miso.
REQ-011 SHALL have port done  out  1: one-cycle pulse at the end of each transfer.
REQ-012 SHALL have port busy  out  1: high in every state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, SETUP, SHIFT and HOLD, with all outputs registered except tx_ready and busy.
REQ-014 SHALL set tx_ready=1 only in IDLE while rst=0; a byte is accepted when tx_valid&&tx_ready at a clk edge.
REQ-015 SHALL, on acceptance, latch tx_data and mode, enter SETUP, and drive cs=0 and mosi=tx_data[7] from the next cycle.
REQ-016 SHALL, in IDLE, drive sclk to the live mode[1] each cycle; in SETUP, SHIFT and HOLD, the latched mode is used and changes to mode or tx_data are ignored.
REQ-017 SHALL run a divider that counts 0..CLK_DIV-1, cleared on every state entry; a tick occurs when the count equals CLK_DIV-1.
REQ-018 SHALL last exactly one tick (CLK_DIV cycles) in SETUP, then enter SHIFT.
REQ-019 SHALL toggle sclk on each of 16 ticks in SHIFT; edges e=1..16, odd e is the leading edge and even e is the trailing edge.
REQ-020 SHALL, when CPHA=0, shift the next bit onto mosi at trailing edges e=2,4..14 and sample miso at leading edges.
REQ-021 SHALL, when CPHA=1, drive bit 7-(e-1)/2 on mosi at leading edges and sample miso at trailing edges.
REQ-022 SHALL, after tick 16, enter HOLD for CLK_DIV cycles with cs=0, sclk at CPOL and mosi held.
REQ-023 SHALL, on leaving HOLD, enter IDLE and set cs=1 and done=1 for one cycle, so that done occurs exactly 18*CLK_DIV cycles after the acceptance edge.
REQ-024 SHALL allow a back-to-back transfer: tx_valid high in the done cycle is accepted, giving cs high for exactly one cycle between bytes.
REQ-025 SHALL leave rx_data stable except in the done cycle, when it is updated with the 8 sampled bits, MSB first.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, cs=1, sclk=0, mosi=0, done=0, rx_data=0x00, divider=0 and tx_ready=0.
REQ-027 SHALL abort any transfer in progress when rst asserts, with no done pulse and rx_data cleared.
REQ-028 SHALL, on the first edge after rst deasserts, load sclk with mode[1] and allow acceptance.

Configuration
REQ-029 SHALL, with SPI_MISO_CAPTURE_EN defined, implement the miso sampling and rx_data update of REQ-020, REQ-021 and REQ-025.
REQ-030 SHALL, without SPI_MISO_CAPTURE_EN, ignore miso, tie rx_data to 0x00, keep all ports present and leave transmit timing unchanged.

Verification
REQ-031 SHALL be verified in mode 0 with CLK_DIV=4, sending 0xA5: mosi sampled at sclk rising edges = 1,0,1,0,0,1,0,1; cs low for 72 cycles; done 72 cycles after acceptance.
REQ-032 SHALL be verified in mode 3, sending 0x3C: sclk idles high, mosi sampled at rising edges = 0,0,1,1,1,1,0,0; exactly 8 rising sclk edges while cs=0.
REQ-033 SHALL be verified with the macro defined, in mode 1, with miso looped to mosi and 0x5A sent: rx_data=0x5A in the done cycle; without the macro, rx_data=0x00.
REQ-034 SHALL be verified with tx_valid held high across two bytes 0x01 then 0x80: cs is high for exactly one cycle between the bytes and two done pulses occur 72 cycles apart.
REQ-035 SHALL be verified with rst asserted 30 cycles into a transfer: cs=1 and sclk=0 immediately, no done pulse, and after release the next byte 0xFF transfers correctly.

Source files
------------

// File: rtl/spi_ctrl_tx.sv
// spi_ctrl_tx: single-byte SPI master (all four CPOL/CPHA modes), MSB first, sclk half-period CLK_DIV clks.
// Optional macro SPI_MISO_CAPTURE_EN adds miso capture into rx_data; without it rx_data reads 0x00.
module spi_ctrl_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] mode,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_EDGE = 5'd16;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] div_r;
    logic [4:0] edge_r;
    logic [4:0] edge_nxt_s;
    logic [7:0] tx_byte_r;
    logic       cpol_r;
    logic       cpha_r;
    logic       sclk_r;
    logic       mosi_r;
    logic       cs_r;
    logic       done_r;
    logic       tick_s;
    logic       accept_s;
    logic       drive_s;
    logic [2:0] bit_idx_s;

    assign tick_s     = (div_r == DIV_LAST);
    assign tx_ready   = (state_r == IDLE) && !rst;
    assign busy       = (state_r != IDLE);
    assign accept_s   = tx_valid && tx_ready;
    assign edge_nxt_s = edge_r + 5'd1;
    // Edge e carries bit 7-floor(e/2) for both phases (CPHA0 even e, CPHA1 odd e).
    assign bit_idx_s  = 3'd7 - edge_nxt_s[3:1];

    assign sclk = sclk_r;
    assign mosi = mosi_r;
    assign cs   = cs_r;
    assign done = done_r;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SETUP;
                else          state_nxt_s = IDLE;
            end
            SETUP: begin
                if (tick_s) state_nxt_s = SHIFT;
                else        state_nxt_s = SETUP;
            end
            SHIFT: begin
                if (tick_s && (edge_nxt_s == LAST_EDGE)) state_nxt_s = HOLD;
                else                                     state_nxt_s = SHIFT;
            end
            HOLD: begin
                if (tick_s) state_nxt_s = IDLE;
                else        state_nxt_s = HOLD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Which sclk edges launch a new mosi bit.
    always_comb begin
        drive_s = 1'b0;
        if (cpha_r) begin
            drive_s = edge_nxt_s[0];
        end else begin
            drive_s = !edge_nxt_s[0] && (edge_nxt_s <= 5'd14);
        end
    end

    // State register and divider, divider restarts on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            div_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || tick_s || (state_r == IDLE)) begin
                div_r <= 8'd0;
            end else begin
                div_r <= div_r + 8'd1;
            end
        end
    end

    // Bus outputs and latched transfer parameters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            cs_r      <= 1'b1;
            done_r    <= 1'b0;
            edge_r    <= 5'd0;
            tx_byte_r <= 8'h00;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    sclk_r <= mode[1];
                    if (accept_s) begin
                        tx_byte_r <= tx_data;
                        cpol_r    <= mode[1];
                        cpha_r    <= mode[0];
                        cs_r      <= 1'b0;
                        mosi_r    <= tx_data[7];
                        edge_r    <= 5'd0;
                    end
                end
                SETUP: begin
                    sclk_r <= cpol_r;
                end
                SHIFT: begin
                    if (tick_s) begin
                        sclk_r <= ~sclk_r;
                        edge_r <= edge_nxt_s;
                        if (drive_s) mosi_r <= tx_byte_r[bit_idx_s];
                    end
                end
                HOLD: begin
                    sclk_r <= cpol_r;
                    if (tick_s) begin
                        cs_r   <= 1'b1;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    cs_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    logic [7:0] rx_shift_r;
    logic [7:0] rx_data_r;
    logic       sample_s;

    // Sampling edges are the opposite parity to the driving edges.
    assign sample_s = edge_nxt_s[0] ^ cpha_r;
    assign rx_data  = rx_data_r;

    // Shift in miso during SHIFT, publish the byte together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) rx_shift_r <= 8'h00;
                end
                SHIFT: begin
                    if (tick_s && sample_s) rx_shift_r <= {rx_shift_r[6:0], miso};
                end
                HOLD: begin
                    if (tick_s) rx_data_r <= rx_shift_r;
                end
                default: begin
                    rx_shift_r <= rx_shift_r;
                end
            endcase
        end
    end
`else
    logic unused_miso_s;

    assign unused_miso_s = miso;
    assign rx_data       = 8'h00;
`endif

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// Scoreboard bench for spi_ctrl_tx: stimulus queues expected bytes, a bus monitor decodes the SPI waveform.
module tb_spi_ctrl_tx;

    localparam int D    = 4;
    localparam int XFER = 18 * D;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] mode;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic [7:0] rx_data;
    logic       done;
    logic       busy;
    logic       inv;

    assign miso = mosi ^ inv;

    spi_ctrl_tx #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mode     (mode),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs       (cs),
        .rx_data  (rx_data),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [7:0] rx;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic send(input logic [7:0] d, input logic [1:0] m, input bit hold, input bit b2b);
        exp_t e;
        int   n;
        e.data = d;
        e.mode = m;
        e.b2b  = b2b;
`ifdef SPI_MISO_CAPTURE_EN
        e.rx = inv ? ~d : d;
`else
        e.rx = 8'h00;
`endif
        exp_q.push_back(e);
        tx_data  = d;
        mode     = m;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tx_ready low for %0d cycles, expected acceptance", n);
        end
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
        tx_data = 8'($urandom);
        mode    = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy after %0d cycles, expected idle", n);
        end
    endtask

    // Bus monitor: decodes each cs-low window and retires one expected byte per done pulse.
    initial begin
        logic       prev_cs   = 1'b1;
        logic       prev_sclk = 1'b0;
        logic       prev_busy = 1'b0;
        logic       prev_rst  = 1'b1;
        logic [7:0] prev_rx   = 8'h00;
        logic [1:0] prev_mode = 2'b00;
        bit         active    = 1'b0;
        int         cyc = 0, lowcnt = 0, edges = 0, rises = 0, nbits = 0, gap = 0;
        logic [7:0] bits = 8'h00;
        exp_t       cur;
        exp_t       item;
        cur = '{8'h00, 2'b00, 8'h00, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                if (active && exp_q.size() > 0) void'(exp_q.pop_front());
                active = 1'b0;
                gap    = 0;
            end else begin
                if (!prev_busy && !prev_rst) check("idle_sclk_follows_cpol", 32'(sclk), 32'(prev_mode[1]));
                if (!done && !prev_rst) check("rx_data_stable", 32'(rx_data), 32'(prev_rx));
                if (prev_cs && !cs) begin
                    active = 1'b1;
                    cyc = 0; lowcnt = 1; edges = 0; rises = 0; nbits = 0; bits = 8'h00;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_transfer: cs fell with empty queue");
                    end else begin
                        cur = exp_q[0];
                        check("sclk_idle_level", 32'(sclk), 32'(cur.mode[1]));
                        if (cur.b2b) check("b2b_cs_high_cycles", 32'(gap), 32'd1);
                    end
                end else if (active) begin
                    cyc++;
                    if (!cs) begin
                        lowcnt++;
                        if (sclk != prev_sclk) begin
                            edges++;
                            if (sclk) rises++;
                            if (sclk == (cur.mode[1] == cur.mode[0])) begin
                                bits = {bits[6:0], mosi};
                                nbits++;
                            end
                        end
                    end
                end else if (cs) begin
                    gap++;
                end
                if (done) begin
                    if (!active || exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_done: done with no transfer pending");
                    end else begin
                        item = exp_q.pop_front();
                        check("mosi_bits", 32'(bits), 32'(item.data));
                        check("sample_count", 32'(nbits), 32'd8);
                        check("sclk_edges", 32'(edges), 32'd16);
                        check("sclk_rises", 32'(rises), 32'd8);
                        check("done_latency", 32'(cyc), 32'(XFER));
                        check("cs_low_cycles", 32'(lowcnt), 32'(XFER));
                        check("rx_data", 32'(rx_data), 32'(item.rx));
                        check("sclk_end_level", 32'(sclk), 32'(item.mode[1]));
                    end
                    active = 1'b0;
                    gap    = 1;
                end
            end
            prev_cs   = cs;
            prev_sclk = sclk;
            prev_busy = busy;
            prev_rst  = rst;
            prev_rx   = rx_data;
            prev_mode = mode;
        end
    end

    // Stimulus: directed scenarios, a reset abort, then randomized transfers.
    initial begin
        int idle;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        mode     = 2'b10;
        inv      = 1'b0;
        #1;
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("release_sclk_cpol", 32'(sclk), 32'd1);
        check("release_tx_ready", 32'(tx_ready), 32'd1);

        send(8'hA5, 2'b00, 1'b0, 1'b0);
        wait_idle();
        send(8'h3C, 2'b11, 1'b0, 1'b0);
        wait_idle();
        send(8'h5A, 2'b01, 1'b0, 1'b0);
        wait_idle();
        send(8'h01, 2'b00, 1'b1, 1'b0);
        send(8'h80, 2'b00, 1'b0, 1'b1);
        wait_idle();

        send(8'h96, 2'b01, 1'b0, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mode = 2'b11;
        rst  = 1'b0;
        @(posedge clk); #1;
        check("abort_release_sclk", 32'(sclk), 32'd1);
        send(8'hFF, 2'b10, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 14; i++) begin
            wait_idle();
            idle = $urandom_range(0, 3);
            repeat (idle) @(posedge clk);
            #1;
            inv = 1'($urandom);
            send(8'($urandom), 2'($urandom), 1'b0, 1'b0);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
